// File: rtl/zubpm_top.sv
// rtl/zubpm_top.sv - AXI4-Lite control registers for ZU BPM: ID, ADC IDELAY tap/load, LEDs
// Optional ADC delay registers built only when ZUBPM_ADC_DLY_EN is defined.
module zubpm_top #(
    parameter int          ADDR_W   = 12,
    parameter int          DLY_W    = 9,
    parameter logic [31:0] ID_VALUE = 32'hDEADBEEF
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [DLY_W-1:0]  adc_dly_val,
    output logic              adc_dly_ld,
    output logic [7:0]        leds
);

    localparam int AW = ADDR_W - 2;
    localparam logic [AW-1:0] W_ID   = AW'(32'h000 >> 2);
    localparam logic [AW-1:0] W_LEDS = AW'(32'h140 >> 2);
`ifdef ZUBPM_ADC_DLY_EN
    localparam logic [AW-1:0] W_DLY  = AW'(32'h020 >> 2);
    localparam logic [AW-1:0] W_STRB = AW'(32'h024 >> 2);
`endif

    logic          wr_rdy;
    logic          bvalid_q;
    logic          ar_rdy;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rd_mux;
    logic [7:0]    led_reg;
    logic          wr_hs;
    logic          rd_hs;
    logic [AW-1:0] wr_word;
    logic [AW-1:0] rd_word;

    assign wr_word = s_axi_awaddr[ADDR_W-1:2];
    assign rd_word = s_axi_araddr[ADDR_W-1:2];
    assign wr_hs   = wr_rdy & s_axi_awvalid & s_axi_wvalid;
    assign rd_hs   = ar_rdy & s_axi_arvalid;

    assign s_axi_awready = wr_rdy;
    assign s_axi_wready  = wr_rdy;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = ar_rdy;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign leds          = led_reg;

    // A response being consumed this cycle counts as not pending, which
    // lets a master holding valid/ready complete one access every 2 cycles.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_rdy   <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            wr_rdy <= s_axi_awvalid & s_axi_wvalid & ~wr_rdy &
                      (~bvalid_q | s_axi_bready);
            if (wr_hs)
                bvalid_q <= 1'b1;
            else if (s_axi_bready)
                bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_rdy   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ar_rdy <= s_axi_arvalid & ~ar_rdy & (~rvalid_q | s_axi_rready);
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset)
            led_reg <= '0;
        else if (wr_hs && wr_word == W_LEDS && s_axi_wstrb[0])
            led_reg <= s_axi_wdata[7:0];
    end

`ifdef ZUBPM_ADC_DLY_EN
    logic [DLY_W-1:0] dly_reg;
    logic [31:0]      dly_merged;
    logic             strb_bit;
    logic             strb_q;
    logic             ld_q;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

    assign dly_merged  = byte_merge(32'(dly_reg), s_axi_wdata, s_axi_wstrb);
    assign adc_dly_val = dly_reg;
    assign adc_dly_ld  = ld_q;

    // Load pulse is a registered rising-edge detect of the strobe bit, so it
    // lands two cycles after the handshake and is never wider than one cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            dly_reg  <= '0;
            strb_bit <= 1'b0;
            strb_q   <= 1'b0;
            ld_q     <= 1'b0;
        end else begin
            if (wr_hs && wr_word == W_DLY)
                dly_reg <= dly_merged[DLY_W-1:0];
            if (wr_hs && wr_word == W_STRB && s_axi_wstrb[0])
                strb_bit <= s_axi_wdata[0];
            strb_q <= strb_bit;
            ld_q   <= strb_bit & ~strb_q;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            W_ID:    rd_mux = ID_VALUE;
            W_LEDS:  rd_mux = {24'b0, led_reg};
            W_DLY:   rd_mux = 32'(dly_reg);
            W_STRB:  rd_mux = {31'b0, strb_bit};
            default: rd_mux = '0;
        endcase
    end
`else
    assign adc_dly_val = '0;
    assign adc_dly_ld  = 1'b0;

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            W_ID:    rd_mux = ID_VALUE;
            W_LEDS:  rd_mux = {24'b0, led_reg};
            default: rd_mux = '0;
        endcase
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_wdata, s_axi_wstrb};

endmodule

// File: tb/tb_zubpm_top.sv
// tb/tb_zubpm_top.sv - scoreboard bench for zubpm_top register block
module tb_zubpm_top;
    localparam int ADDR_W = 12;
    localparam int DLY_W  = 9;
`ifdef ZUBPM_ADC_DLY_EN
    localparam bit DLY_EN = 1'b1;
`else
    localparam bit DLY_EN = 1'b0;
`endif

    logic              tb_ACLK = 1'b0;
    logic              areset;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [DLY_W-1:0]  adc_dly_val;
    logic              adc_dly_ld;
    logic [7:0]        leds;

    always #5 tb_ACLK = ~tb_ACLK;

    zubpm_top dut (
        .aclk(tb_ACLK), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .adc_dly_val(adc_dly_val), .adc_dly_ld(adc_dly_ld), .leds(leds)
    );

    typedef struct {
        logic [31:0] data;
        string       name;
    } rexp_t;

    rexp_t rq[$];
    string bq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    ld_count = 0;
    logic  ld_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is transferred.
    always @(negedge tb_ACLK) begin
        if (!areset) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) begin
                    check("unexpected_bvalid", 32'd1, 32'd0);
                end else begin
                    string nm;
                    nm = bq.pop_front();
                    check({nm, "_bresp"}, 32'(s_axi_bresp), 32'd0);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    check({e.name, "_rdata"}, s_axi_rdata, e.data);
                    check({e.name, "_rresp"}, 32'(s_axi_rresp), 32'd0);
                end
            end
            if (adc_dly_ld) begin
                ld_count++;
                check("ld_width", 32'(ld_prev), 32'd0);
            end
        end
        ld_prev = adc_dly_ld;
    end

    task automatic start_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input logic [3:0] be, input string name);
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = be;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        bq.push_back(name);
    endtask

    // Returns 1 ns into the cycle after the handshake.
    task automatic finish_write(input string name);
        int n = 0;
        do begin
            @(negedge tb_ACLK);
            n++;
        end while (!(s_axi_awready && s_axi_wready) && n < 50);
        if (!(s_axi_awready && s_axi_wready))
            check({name, "_aw_timeout"}, 32'd0, 32'd1);
        @(posedge tb_ACLK);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] be, input string name);
        start_write(a, d, be, name);
        finish_write(name);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp,
                            input string name);
        int n = 0;
        rexp_t e;
        e.data = exp;
        e.name = name;
        rq.push_back(e);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        do begin
            @(negedge tb_ACLK);
            n++;
        end while (!s_axi_arready && n < 50);
        if (!s_axi_arready)
            check({name, "_ar_timeout"}, 32'd0, 32'd1);
        @(posedge tb_ACLK);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tb_ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        tick(20);
        areset = 1'b0;
        tick(1);
        check("reset_outs", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                             s_axi_rvalid, adc_dly_ld, 1'b0, adc_dly_val, 8'h00, leds}, 32'd0);

        axi_read(12'h000, 32'hDEADBEEF, "id");
        axi_read(12'h003, 32'hDEADBEEF, "id_unaligned");

        // Delay tap value follows each write one cycle after the handshake.
        axi_write(12'h020, 32'h1, 4'hF, "dly1");
        check("dly_val_1", 32'(adc_dly_val), DLY_EN ? 32'h1 : 32'h0);
        axi_write(12'h020, 32'h2, 4'hF, "dly2");
        check("dly_val_2", 32'(adc_dly_val), DLY_EN ? 32'h2 : 32'h0);
        axi_write(12'h020, 32'h3, 4'hF, "dly3");
        check("dly_val_3", 32'(adc_dly_val), DLY_EN ? 32'h3 : 32'h0);
        axi_read(12'h020, DLY_EN ? 32'h3 : 32'h0, "dly_rd3");
        axi_write(12'h020, 32'hFFFF_FFFF, 4'hF, "dly_all");
        axi_read(12'h020, DLY_EN ? 32'h1FF : 32'h0, "dly_rd_max");
        axi_write(12'h020, 32'h0000_0000, 4'b0001, "dly_byte0");
        check("dly_val_byte0", 32'(adc_dly_val), DLY_EN ? 32'h100 : 32'h0);
        tick(3);
        check("ld_none_after_dly", 32'(ld_count), 32'd0);

        // Strobe: one pulse for the 0->1 transition only.
        axi_write(12'h024, 32'h0, 4'hF, "strb0");
        axi_write(12'h024, 32'h1, 4'hF, "strb1");
        check("ld_n1", 32'(adc_dly_ld), 32'd0);
        tick(1);
        check("ld_n2", 32'(adc_dly_ld), 32'(DLY_EN));
        tick(1);
        check("ld_n3", 32'(adc_dly_ld), 32'd0);
        axi_read(12'h024, DLY_EN ? 32'h1 : 32'h0, "strb_rd1");
        axi_write(12'h024, 32'h1, 4'hF, "strb1_again");
        axi_write(12'h024, 32'h1, 4'hF, "strb1_again2");
        axi_write(12'h024, 32'h0, 4'hF, "strb0_end");
        tick(3);
        check("ld_count_single", 32'(ld_count), 32'(DLY_EN));

        // LEDs with byte enables.
        axi_write(12'h140, 32'h55, 4'hF, "leds55");
        check("leds_55", 32'(leds), 32'h55);
        axi_read(12'h140, 32'h55, "leds_rd55");
        axi_write(12'h140, 32'hFFFF_FFAA, 4'b0000, "leds_nostrb");
        check("leds_nostrb", 32'(leds), 32'h55);
        axi_write(12'h140, 32'hAABB_CCA5, 4'b0001, "leds_b0");
        check("leds_b0", 32'(leds), 32'hA5);

        // Unmapped offsets.
        axi_read(12'h100, 32'h0, "unmapped_rd");
        axi_write(12'h100, 32'h1234_5678, 4'hF, "unmapped_wr");
        check("leds_after_unmapped", 32'(leds), 32'hA5);

        // Back-to-back reads with arvalid held: one accept every 2 cycles.
        for (int i = 0; i < 4; i++) begin
            rexp_t e;
            e.data = 32'hDEADBEEF;
            e.name = "b2b";
            rq.push_back(e);
        end
        s_axi_araddr  = 12'h000;
        s_axi_arvalid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge tb_ACLK);
            if (s_axi_arready) cnt++;
        end
        @(posedge tb_ACLK);
        #1;
        s_axi_arvalid = 1'b0;
        check("b2b_accepts", 32'(cnt), 32'd4);

        // bready stall: response holds, next write blocked.
        s_axi_bready = 1'b0;
        axi_write(12'h140, 32'h33, 4'hF, "stall_a");
        check("leds_33", 32'(leds), 32'h33);
        start_write(12'h140, 32'h0F, 4'hF, "stall_b");
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            if (s_axi_bvalid && !s_axi_awready && !s_axi_wready) cnt++;
        end
        check("stall_held", 32'(cnt), 32'd5);
        check("leds_stalled", 32'(leds), 32'h33);
        @(posedge tb_ACLK);
        #1;
        s_axi_bready = 1'b1;
        finish_write("stall_b");
        check("leds_0f", 32'(leds), 32'h0F);
        tick(2);

        // Reset mid-transaction drops bvalid and suppresses the load pulse.
        s_axi_bready = 1'b0;
        axi_write(12'h024, 32'h1, 4'hF, "rst_strb");
        check("rst_bvalid_pre", 32'(s_axi_bvalid), 32'd1);
        areset = 1'b1;
        tick(1);
        check("rst_bvalid_drop", 32'(s_axi_bvalid), 32'd0);
        check("rst_ld_suppressed", 32'(adc_dly_ld), 32'd0);
        bq.delete();
        tick(2);
        areset = 1'b0;
        s_axi_bready = 1'b1;
        tick(3);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_dly", 32'(adc_dly_val), 32'd0);
        check("ld_count_final", 32'(ld_count), 32'(DLY_EN));
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("bq_drained", 32'(bq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
